// File: rtl/ex_stage.sv
// Y86 execute stage: ALU, condition evaluation and CC register feeding a
// registered E->M pipeline register with stall/bubble control.
module ex_stage #(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             bubble_i,
  input  logic             set_cc_en_i,
  input  logic             valid_i,
  input  logic [7:0]       icode_i,
  input  logic [7:0]       ifun_i,
  input  logic [WIDTH-1:0] valA_i,
  input  logic [WIDTH-1:0] valB_i,
  input  logic [WIDTH-1:0] valC_i,
  input  logic [7:0]       dstE_i,
  output logic             valid_o,
  output logic [7:0]       icode_o,
  output logic [WIDTH-1:0] valE_o,
  output logic [WIDTH-1:0] valA_o,
  output logic [7:0]       dstE_o,
  output logic             cnd_o,
  output logic [2:0]       cc_o,
  output logic             err_o
);

  localparam logic [7:0] I_NOP    = 8'h01;
  localparam logic [7:0] I_CMOVXX = 8'h02;
  localparam logic [7:0] I_IRMOVL = 8'h03;
  localparam logic [7:0] I_RMMOVL = 8'h04;
  localparam logic [7:0] I_MRMOVL = 8'h05;
  localparam logic [7:0] I_OPL    = 8'h06;
  localparam logic [7:0] I_JXX    = 8'h07;
  localparam logic [7:0] I_CALL   = 8'h08;
  localparam logic [7:0] I_RET    = 8'h09;
  localparam logic [7:0] I_PUSHL  = 8'h0A;
  localparam logic [7:0] I_POPL   = 8'h0B;
  localparam logic [7:0] RNONE    = 8'h0F;
  localparam logic [2:0] CC_RESET = 3'b100;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic             valid_q, valid_d;
  logic [7:0]       icode_q, icode_d;
  logic [WIDTH-1:0] valE_q, valE_d;
  logic [WIDTH-1:0] valA_q, valA_d;
  logic [7:0]       dstE_q, dstE_d;
  logic             cnd_q, cnd_d;
  logic [2:0]       cc_q, cc_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] add_res, sub_res, result_c;
  logic             opl_ok, err_c, cond_c, cnd_c, cc_load;
  logic             zf_c, sf_c, of_c;
  logic             zf_q, sf_q, of_q;

  assign add_res = valB_i + valA_i;
  assign sub_res = valB_i - valA_i;
  assign opl_ok  = (icode_i == I_OPL) && (ifun_i <= 8'd3);
  assign err_c   = (icode_i > I_POPL) || ((icode_i == I_OPL) && !opl_ok);

  always_comb begin
    result_c = '0;
    case (icode_i)
      I_CMOVXX:         result_c = valA_i;
      I_IRMOVL:         result_c = valC_i;
      I_RMMOVL, I_MRMOVL: result_c = valB_i + valC_i;
      I_OPL: begin
        case (ifun_i)
          8'd0:    result_c = add_res;
          8'd1:    result_c = sub_res;
          8'd2:    result_c = valB_i & valA_i;
          8'd3:    result_c = valB_i ^ valA_i;
          default: result_c = '0;
        endcase
      end
      I_CALL, I_PUSHL:  result_c = valB_i - STEP;
      I_RET, I_POPL:    result_c = valB_i + STEP;
      default:          result_c = '0;
    endcase
  end

  // Overflow compares operand signs against the result sign; logic ops never overflow.
  always_comb begin
    zf_c = (result_c == '0);
    sf_c = result_c[WIDTH-1];
    of_c = 1'b0;
    if (ifun_i == 8'd0)
      of_c = (valA_i[WIDTH-1] == valB_i[WIDTH-1]) && (result_c[WIDTH-1] != valA_i[WIDTH-1]);
    else if (ifun_i == 8'd1)
      of_c = (valA_i[WIDTH-1] != valB_i[WIDTH-1]) && (result_c[WIDTH-1] != valB_i[WIDTH-1]);
  end

  assign {zf_q, sf_q, of_q} = cc_q;

  // Conditions use the registered CC, never the flags of the instruction in E.
  always_comb begin
    cond_c = 1'b0;
    case (ifun_i)
      8'd0:    cond_c = 1'b1;
      8'd1:    cond_c = (sf_q ^ of_q) | zf_q;
      8'd2:    cond_c = sf_q ^ of_q;
      8'd3:    cond_c = zf_q;
      8'd4:    cond_c = ~zf_q;
      8'd5:    cond_c = ~(sf_q ^ of_q);
      8'd6:    cond_c = ~(sf_q ^ of_q) & ~zf_q;
      default: cond_c = 1'b0;
    endcase
  end

  assign cnd_c   = ((icode_i == I_CMOVXX) || (icode_i == I_JXX)) ? cond_c : 1'b0;
  assign cc_load = valid_i && opl_ok && set_cc_en_i && !stall_i && !bubble_i;

  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    valE_d  = valE_q;
    valA_d  = valA_q;
    dstE_d  = dstE_q;
    cnd_d   = cnd_q;
    err_d   = err_q;
    cc_d    = cc_load ? {zf_c, sf_c, of_c} : cc_q;
    if (!stall_i) begin
      if (bubble_i || !valid_i) begin
        valid_d = 1'b0;
        icode_d = I_NOP;
        valE_d  = '0;
        valA_d  = '0;
        dstE_d  = RNONE;
        cnd_d   = 1'b0;
        err_d   = 1'b0;
      end else begin
        valid_d = 1'b1;
        icode_d = icode_i;
        valE_d  = result_c;
        valA_d  = valA_i;
        cnd_d   = cnd_c;
        err_d   = err_c;
        if (err_c || ((icode_i == I_CMOVXX) && !cnd_c)) dstE_d = RNONE;
        else                                           dstE_d = dstE_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      icode_q <= I_NOP;
      valE_q  <= '0;
      valA_q  <= '0;
      dstE_q  <= RNONE;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      cc_q    <= CC_RESET;
    end else begin
      valid_q <= valid_d;
      icode_q <= icode_d;
      valE_q  <= valE_d;
      valA_q  <= valA_d;
      dstE_q  <= dstE_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
      cc_q    <= cc_d;
    end
  end

  assign valid_o = valid_q;
  assign icode_o = icode_q;
  assign valE_o  = valE_q;
  assign valA_o  = valA_q;
  assign dstE_o  = dstE_q;
  assign cnd_o   = cnd_q;
  assign cc_o    = cc_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a 32-bit instance for the main sequence and
// a 16-bit instance for the narrow-width overflow and error cases.
module tb_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Shared controls
  logic rst, stall, bubble, set_cc_en;

  // 32-bit instance
  logic        valid_i;
  logic [7:0]  icode_i, ifun_i, dstE_i;
  logic [31:0] valA_i, valB_i, valC_i;
  logic        valid_o, cnd_o, err_o;
  logic [7:0]  icode_o, dstE_o;
  logic [31:0] valE_o, valA_o;
  logic [2:0]  cc_o;

  ex_stage #(.WIDTH(32), .STACK_STEP(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .bubble_i(bubble),
    .set_cc_en_i(set_cc_en), .valid_i(valid_i), .icode_i(icode_i),
    .ifun_i(ifun_i), .valA_i(valA_i), .valB_i(valB_i), .valC_i(valC_i),
    .dstE_i(dstE_i), .valid_o(valid_o), .icode_o(icode_o), .valE_o(valE_o),
    .valA_o(valA_o), .dstE_o(dstE_o), .cnd_o(cnd_o), .cc_o(cc_o), .err_o(err_o)
  );

  // 16-bit instance
  logic        n_valid_i;
  logic [7:0]  n_icode_i, n_ifun_i, n_dstE_i;
  logic [15:0] n_valA_i, n_valB_i, n_valC_i;
  logic        n_valid_o, n_cnd_o, n_err_o;
  logic [7:0]  n_icode_o, n_dstE_o;
  logic [15:0] n_valE_o, n_valA_o;
  logic [2:0]  n_cc_o;

  ex_stage #(.WIDTH(16), .STACK_STEP(2)) dut16 (
    .clk(clk), .rst(rst), .stall_i(stall), .bubble_i(bubble),
    .set_cc_en_i(set_cc_en), .valid_i(n_valid_i), .icode_i(n_icode_i),
    .ifun_i(n_ifun_i), .valA_i(n_valA_i), .valB_i(n_valB_i), .valC_i(n_valC_i),
    .dstE_i(n_dstE_i), .valid_o(n_valid_o), .icode_o(n_icode_o), .valE_o(n_valE_o),
    .valA_o(n_valA_o), .dstE_o(n_dstE_o), .cnd_o(n_cnd_o), .cc_o(n_cc_o), .err_o(n_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ic, input logic [7:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [7:0] d);
    valid_i = v; icode_i = ic; ifun_i = fn;
    valA_i = a; valB_i = b; valC_i = c; dstE_i = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; bubble = 1'b0; set_cc_en = 1'b1;
    drive(1'b1, 8'h06, 8'h01, 32'd1, 32'd9, 32'd0, 8'h02);
    n_valid_i = 1'b0; n_icode_i = 8'h01; n_ifun_i = 8'h00;
    n_valA_i = '0; n_valB_i = '0; n_valC_i = '0; n_dstE_i = 8'h0F;
    tick();
    // Reset overrides stall and loads the bubble
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_icode", 64'(icode_o), 64'h01);
    chk("rst_valE",  64'(valE_o),  64'h0);
    chk("rst_valA",  64'(valA_o),  64'h0);
    chk("rst_dstE",  64'(dstE_o),  64'h0F);
    chk("rst_cnd",   64'(cnd_o),   64'h0);
    chk("rst_err",   64'(err_o),   64'h0);
    chk("rst_cc",    64'(cc_o),    64'h4);
    chk("rst_cc16",  64'(n_cc_o),  64'h4);

    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 8'h07, 8'h03, 32'd0, 32'd0, 32'h40, 8'h0F);
    tick();
    chk("je_cnd",   64'(cnd_o),   64'h1);
    chk("je_cc",    64'(cc_o),    64'h4);
    chk("je_valid", 64'(valid_o), 64'h1);
    chk("je_icode", 64'(icode_o), 64'h07);

    drive(1'b1, 8'h06, 8'h01, 32'd1, 32'h80000000, 32'd0, 8'h02);
    tick();
    chk("sub_valE", 64'(valE_o), 64'h7FFFFFFF);
    chk("sub_cc",   64'(cc_o),   64'h1);
    chk("sub_dstE", 64'(dstE_o), 64'h02);
    chk("sub_valA", 64'(valA_o), 64'h1);

    drive(1'b1, 8'h07, 8'h02, 32'd0, 32'd0, 32'd0, 8'h0F);
    tick();
    chk("jl_cnd", 64'(cnd_o), 64'h1);
    drive(1'b1, 8'h07, 8'h06, 32'd0, 32'd0, 32'd0, 8'h0F);
    tick();
    chk("jg_cnd", 64'(cnd_o), 64'h0);
    drive(1'b1, 8'h07, 8'h07, 32'd0, 32'd0, 32'd0, 8'h0F);
    tick();
    chk("j7_cnd", 64'(cnd_o), 64'h0);
    drive(1'b1, 8'h07, 8'h00, 32'd0, 32'd0, 32'd0, 8'h0F);
    tick();
    chk("jmp_cnd", 64'(cnd_o), 64'h1);

    // Stalled ADD must leave outputs and CC untouched
    stall = 1'b1;
    drive(1'b1, 8'h06, 8'h00, 32'd5, 32'hFFFFFFFB, 32'd0, 8'h04);
    tick();
    chk("stall_icode", 64'(icode_o), 64'h07);
    chk("stall_cnd",   64'(cnd_o),   64'h1);
    chk("stall_cc",    64'(cc_o),    64'h1);
    stall = 1'b0;
    tick();
    chk("add_valE", 64'(valE_o), 64'h0);
    chk("add_cc",   64'(cc_o),   64'h4);
    chk("add_dstE", 64'(dstE_o), 64'h04);

    drive(1'b1, 8'h02, 8'h06, 32'h1234, 32'd0, 32'd0, 8'h03);
    tick();
    chk("cmovg_dstE", 64'(dstE_o), 64'h0F);
    chk("cmovg_cnd",  64'(cnd_o),  64'h0);
    chk("cmovg_valE", 64'(valE_o), 64'h1234);
    drive(1'b1, 8'h02, 8'h03, 32'h5678, 32'd0, 32'd0, 8'h03);
    tick();
    chk("cmove_dstE", 64'(dstE_o), 64'h03);
    chk("cmove_cnd",  64'(cnd_o),  64'h1);

    set_cc_en = 1'b0;
    drive(1'b1, 8'h06, 8'h00, 32'd1, 32'd1, 32'd0, 8'h01);
    tick();
    chk("nocc_valE", 64'(valE_o), 64'h2);
    chk("nocc_cc",   64'(cc_o),   64'h4);
    set_cc_en = 1'b1;

    bubble = 1'b1;
    drive(1'b1, 8'h0A, 8'h00, 32'd7, 32'h100, 32'd0, 8'h04);
    tick();
    chk("bub_valid", 64'(valid_o), 64'h0);
    chk("bub_icode", 64'(icode_o), 64'h01);
    chk("bub_valE",  64'(valE_o),  64'h0);
    chk("bub_dstE",  64'(dstE_o),  64'h0F);
    bubble = 1'b0;
    tick();
    chk("push_valE",  64'(valE_o),  64'hFC);
    chk("push_icode", 64'(icode_o), 64'h0A);
    chk("push_valA",  64'(valA_o),  64'h7);
    stall = 1'b1; bubble = 1'b1;
    drive(1'b1, 8'h0B, 8'h00, 32'd0, 32'h100, 32'd0, 8'h04);
    tick();
    chk("sb_valid", 64'(valid_o), 64'h1);
    chk("sb_valE",  64'(valE_o),  64'hFC);
    chk("sb_icode", 64'(icode_o), 64'h0A);
    stall = 1'b0; bubble = 1'b0;
    tick();
    chk("pop_valE", 64'(valE_o), 64'h104);

    drive(1'b1, 8'h08, 8'h00, 32'd0, 32'h200, 32'd0, 8'h04);
    tick();
    chk("call_valE", 64'(valE_o), 64'h1FC);
    drive(1'b1, 8'h09, 8'h00, 32'd0, 32'h200, 32'd0, 8'h04);
    tick();
    chk("ret_valE", 64'(valE_o), 64'h204);
    drive(1'b1, 8'h03, 8'h00, 32'd0, 32'd0, 32'h55, 8'h01);
    tick();
    chk("irmov_valE", 64'(valE_o), 64'h55);
    drive(1'b1, 8'h05, 8'h00, 32'd0, 32'h10, 32'h8, 8'h01);
    tick();
    chk("mrmov_valE", 64'(valE_o), 64'h18);
    drive(1'b1, 8'h00, 8'h00, 32'd3, 32'd4, 32'd5, 8'h01);
    tick();
    chk("halt_valE", 64'(valE_o), 64'h0);
    chk("halt_err",  64'(err_o),  64'h0);

    drive(1'b1, 8'h06, 8'h02, 32'h3C, 32'hF0, 32'd0, 8'h01);
    tick();
    chk("and_valE", 64'(valE_o), 64'h30);
    chk("and_cc",   64'(cc_o),   64'h0);
    drive(1'b1, 8'h06, 8'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 8'h01);
    tick();
    chk("xor0_valE", 64'(valE_o), 64'h0);
    chk("xor0_cc",   64'(cc_o),   64'h4);
    drive(1'b1, 8'h06, 8'h03, 32'd0, 32'h80000000, 32'd0, 8'h01);
    tick();
    chk("xorn_valE", 64'(valE_o), 64'h80000000);
    chk("xorn_cc",   64'(cc_o),   64'h2);

    drive(1'b1, 8'h06, 8'h04, 32'd1, 32'd1, 32'd0, 8'h01);
    tick();
    chk("badfn_valE", 64'(valE_o), 64'h0);
    chk("badfn_err",  64'(err_o),  64'h1);
    chk("badfn_cc",   64'(cc_o),   64'h2);
    drive(1'b1, 8'h0C, 8'h00, 32'd1, 32'd1, 32'd1, 8'h05);
    tick();
    chk("badic_err",   64'(err_o),   64'h1);
    chk("badic_valE",  64'(valE_o),  64'h0);
    chk("badic_dstE",  64'(dstE_o),  64'h0F);
    chk("badic_valid", 64'(valid_o), 64'h1);

    drive(1'b0, 8'h06, 8'h00, 32'd0, 32'd0, 32'd0, 8'h01);
    tick();
    chk("inv_valid", 64'(valid_o), 64'h0);
    chk("inv_err",   64'(err_o),   64'h0);
    chk("inv_cc",    64'(cc_o),    64'h2);

    // Reset during an OPL discards it; next JXX E sees reset CC
    rst = 1'b1;
    drive(1'b1, 8'h06, 8'h01, 32'd1, 32'd2, 32'd0, 8'h01);
    tick();
    chk("mrst_valid", 64'(valid_o), 64'h0);
    chk("mrst_cc",    64'(cc_o),    64'h4);
    rst = 1'b0;
    drive(1'b1, 8'h07, 8'h03, 32'd0, 32'd0, 32'd0, 8'h0F);
    tick();
    chk("mrst_je", 64'(cnd_o), 64'h1);

    drive(1'b0, 8'h01, 8'h00, 32'd0, 32'd0, 32'd0, 8'h0F);
    n_valid_i = 1'b1; n_icode_i = 8'h06; n_ifun_i = 8'h00;
    n_valA_i = 16'h7FFF; n_valB_i = 16'h0001; n_dstE_i = 8'h02;
    tick();
    chk("w16_valE", 64'(n_valE_o), 64'h8000);
    chk("w16_cc",   64'(n_cc_o),   64'h3);
    n_icode_i = 8'h0C;
    tick();
    chk("w16_err",  64'(n_err_o),  64'h1);
    chk("w16_dstE", 64'(n_dstE_o), 64'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
